// File: rtl/commit_monitor.sv
// End-of-run monitor: counts cycles, commits, stalls and flushes while running,
// then reads the a0/a1 mappings and values through the RAT and PRF and holds a final snapshot.
module commit_monitor #(
    parameter int unsigned MAX_CYCLES      = 20000,
    parameter int unsigned STALL_THRESHOLD = 200,
    parameter int unsigned PREG_W          = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              commit_i,
    input  logic              flush_i,
    input  logic              recover_i,
    output logic              rat_rd_en_o,
    output logic [4:0]        rat_rd_arch_o,
    input  logic [PREG_W-1:0] rat_rd_preg_i,
    output logic              prf_rd_en_o,
    output logic [PREG_W-1:0] prf_rd_addr_o,
    input  logic [31:0]       prf_rd_data_i,
    output logic [63:0]       cycle_count_o,
    output logic [63:0]       commit_count_o,
    output logic [31:0]       stall_ctr_o,
    output logic [31:0]       flush_count_o,
    output logic              done_o,
    output logic [1:0]        done_cause_o,
    output logic [PREG_W-1:0] a0_preg_o,
    output logic [PREG_W-1:0] a1_preg_o,
    output logic [31:0]       a0_val_o,
    output logic [31:0]       a1_val_o
);

    localparam int unsigned CNT_W  = 64;
    localparam int unsigned SAT_W  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ARCH_W = 5;

    localparam logic [ARCH_W-1:0] ARCH_A0 = ARCH_W'(10);
    localparam logic [ARCH_W-1:0] ARCH_A1 = ARCH_W'(11);
    localparam logic [SAT_W-1:0]  SAT_MAX = '1;

    typedef enum logic [2:0] {
        S_RUN  = 3'd0,
        S_RAT0 = 3'd1,
        S_RAT1 = 3'd2,
        S_PRF0 = 3'd3,
        S_PRF1 = 3'd4,
        S_FIN  = 3'd5,
        S_DONE = 3'd6
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cycle_q, cycle_d;
    logic [CNT_W-1:0]    commit_q, commit_d;
    logic [SAT_W-1:0]    stall_q, stall_d;
    logic [SAT_W-1:0]    flush_q, flush_d;
    logic [1:0]          cause_q, cause_d;
    logic [PREG_W-1:0]   a0_preg_q, a0_preg_d;
    logic [PREG_W-1:0]   a1_preg_q, a1_preg_d;
    logic [DATA_W-1:0]   a0_val_q, a0_val_d;
    logic [DATA_W-1:0]   a1_val_q, a1_val_d;
    logic                rat_en_q, rat_en_d;
    logic [ARCH_W-1:0]   rat_arch_q, rat_arch_d;
    logic                prf_en_q, prf_en_d;
    logic [PREG_W-1:0]   prf_addr_q, prf_addr_d;
    logic                done_q, done_d;

    logic stall_hit_c;
    logic cycle_hit_c;

    assign stall_hit_c = (stall_q >= SAT_W'(STALL_THRESHOLD));
    assign cycle_hit_c = (cycle_q >= CNT_W'(MAX_CYCLES));

    // Next-state, counter and snapshot logic; read outputs are registered from the next state
    always_comb begin
        state_d    = state_q;
        cycle_d    = cycle_q;
        commit_d   = commit_q;
        stall_d    = stall_q;
        flush_d    = flush_q;
        cause_d    = cause_q;
        a0_preg_d  = a0_preg_q;
        a1_preg_d  = a1_preg_q;
        a0_val_d   = a0_val_q;
        a1_val_d   = a1_val_q;
        rat_en_d   = 1'b0;
        rat_arch_d = '0;
        prf_en_d   = 1'b0;
        prf_addr_d = '0;
        done_d     = 1'b0;

        case (state_q)
            S_RUN: begin
                if (stall_hit_c || cycle_hit_c) begin
                    state_d = S_RAT0;
                    cause_d = {cycle_hit_c, stall_hit_c};
                end else begin
                    cycle_d = cycle_q + CNT_W'(1);
                    if (commit_i) begin
                        commit_d = commit_q + CNT_W'(1);
                        stall_d  = '0;
                    end else if (stall_q != SAT_MAX) begin
                        stall_d = stall_q + SAT_W'(1);
                    end
                    if ((flush_i || recover_i) && (flush_q != SAT_MAX)) begin
                        flush_d = flush_q + SAT_W'(1);
                    end
                end
            end
            S_RAT0: state_d = S_RAT1;
            S_RAT1: begin
                a0_preg_d = rat_rd_preg_i;
                state_d   = S_PRF0;
            end
            S_PRF0: begin
                a1_preg_d = rat_rd_preg_i;
                state_d   = S_PRF1;
            end
            S_PRF1: begin
                a0_val_d = prf_rd_data_i;
                state_d  = S_FIN;
            end
            S_FIN: begin
                a1_val_d = prf_rd_data_i;
                state_d  = S_DONE;
            end
            S_DONE:  state_d = S_DONE;
            default: state_d = S_RUN;
        endcase

        case (state_d)
            S_RAT0: begin
                rat_en_d   = 1'b1;
                rat_arch_d = ARCH_A0;
            end
            S_RAT1: begin
                rat_en_d   = 1'b1;
                rat_arch_d = ARCH_A1;
            end
            S_PRF0: begin
                prf_en_d   = 1'b1;
                prf_addr_d = a0_preg_d;
            end
            S_PRF1: begin
                prf_en_d   = 1'b1;
                prf_addr_d = a1_preg_d;
            end
            S_DONE:  done_d = 1'b1;
            default: ;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RUN;
            cycle_q    <= '0;
            commit_q   <= '0;
            stall_q    <= '0;
            flush_q    <= '0;
            cause_q    <= '0;
            a0_preg_q  <= '0;
            a1_preg_q  <= '0;
            a0_val_q   <= '0;
            a1_val_q   <= '0;
            rat_en_q   <= 1'b0;
            rat_arch_q <= '0;
            prf_en_q   <= 1'b0;
            prf_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cycle_q    <= cycle_d;
            commit_q   <= commit_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
            cause_q    <= cause_d;
            a0_preg_q  <= a0_preg_d;
            a1_preg_q  <= a1_preg_d;
            a0_val_q   <= a0_val_d;
            a1_val_q   <= a1_val_d;
            rat_en_q   <= rat_en_d;
            rat_arch_q <= rat_arch_d;
            prf_en_q   <= prf_en_d;
            prf_addr_q <= prf_addr_d;
            done_q     <= done_d;
        end
    end

    assign rat_rd_en_o    = rat_en_q;
    assign rat_rd_arch_o  = rat_arch_q;
    assign prf_rd_en_o    = prf_en_q;
    assign prf_rd_addr_o  = prf_addr_q;
    assign cycle_count_o  = cycle_q;
    assign commit_count_o = commit_q;
    assign stall_ctr_o    = stall_q;
    assign flush_count_o  = flush_q;
    assign done_o         = done_q;
    assign done_cause_o   = cause_q;
    assign a0_preg_o      = a0_preg_q;
    assign a1_preg_o      = a1_preg_q;
    assign a0_val_o       = a0_val_q;
    assign a1_val_o       = a1_val_q;

endmodule

// File: doc/commit_monitor.md
COMMIT_MONITOR -- requirements
Module: commit_monitor

Interface
REQ-001 SHALL have parameter MAX_CYCLES, default 20000, cycle limit before forced stop.
REQ-002 SHALL have parameter STALL_THRESHOLD, default 200, consecutive commit-free cycles before stop.
REQ-003 SHALL have parameter PREG_W, default 6, physical register index width.
REQ-004 SHALL use one clock and an asynchronous active-low reset (fixed), ports below:
REQ-005 clk  input  1  core clock; all state updates on posedge.
REQ-006 rst_n  input  1  asynchronous active-low reset.
REQ-007 commit_i  input  1  ROB retire pulse (free_req); one commit per asserted cycle.
REQ-008 flush_i  input  1  pipeline flush event.
REQ-009 recover_i  input  1  branch-recovery event.
REQ-010 rat_rd_en_o  output  1  RAT read request.
REQ-011 rat_rd_arch_o  output  5  architectural register to read.
REQ-012 rat_rd_preg_i  input  PREG_W  RAT data, valid the cycle after request.
REQ-013 prf_rd_en_o  output  1  PRF read request.
REQ-014 prf_rd_addr_o  output  PREG_W  physical register to read.
REQ-015 prf_rd_data_i  input  32  PRF data, valid the cycle after request.
REQ-016 cycle_count_o  output  64  cycles counted in RUN.
REQ-017 commit_count_o  output  64  commits counted in RUN.
REQ-018 stall_ctr_o  output  32  current consecutive commit-free cycles.
REQ-019 flush_count_o  output  32  cycles with flush_i or recover_i high.
REQ-020 done_o  output  1  final snapshot valid.
REQ-021 done_cause_o  output  2  01 stall, 10 max cycles, 11 both.
REQ-022 a0_preg_o / a1_preg_o  output  PREG_W each  captured mappings of x10 / x11.
REQ-023 a0_val_o / a1_val_o  output  32 each  captured values of x10 / x11.

Function
REQ-024 SHALL implement FSM RUN -> RAT0 -> RAT1 -> PRF0 -> PRF1 -> FIN -> DONE; DONE is terminal until reset.
REQ-025 In RUN, cycle_count SHALL increment by 1 every cycle.
REQ-026 In RUN, commit_i=1 SHALL increment commit_count and clear stall_ctr to 0; commit_i=0 SHALL increment stall_ctr, saturating at 0xFFFF_FFFF.
REQ-027 In RUN, flush_count SHALL increment once per cycle where flush_i|recover_i, saturating at 0xFFFF_FFFF.
REQ-028 RUN SHALL exit to RAT0 when registered stall_ctr>=STALL_THRESHOLD or cycle_count>=MAX_CYCLES; done_cause latched same edge, both true -> 11.
REQ-029 On the exit edge, counters SHALL not update; all counters SHALL hold frozen in every non-RUN state; inputs commit_i/flush_i/recover_i SHALL be ignored outside RUN.
REQ-030 RAT0: rat_rd_en_o=1, rat_rd_arch_o=10.
REQ-031 RAT1: capture rat_rd_preg_i into a0_preg; rat_rd_en_o=1, rat_rd_arch_o=11.
REQ-032 PRF0: capture rat_rd_preg_i into a1_preg; prf_rd_en_o=1, prf_rd_addr_o=a0_preg.
REQ-033 PRF1: capture prf_rd_data_i into a0_val; prf_rd_en_o=1, prf_rd_addr_o=a1_preg.
REQ-034 FIN: capture prf_rd_data_i into a1_val; next state DONE.
REQ-035 done_o SHALL be 1 only in DONE, registered; exactly 5 cycles after the RUN exit edge.
REQ-036 Read-enable outputs SHALL be 0 and address outputs 0 in all states not listed above.
REQ-037 Count outputs SHALL be driven directly from registers (no combinational path from inputs).

Reset
REQ-038 rst_n low SHALL asynchronously force state RUN and all counters, captured registers, done_o, done_cause_o and read outputs to 0, including mid-snapshot.
REQ-039 First count SHALL occur on the first posedge with rst_n high.

Verification
REQ-040 commit_i=1 for 10 cycles then 0 -> stall_ctr reaches 200, done_cause=01, commit_count=10, done_o 5 cycles after exit.
REQ-041 commit_i=1 every cycle, MAX_CYCLES=50 -> exit when cycle_count=50, done_cause=10, commit_count=50, stall_ctr=0.
REQ-042 MAX_CYCLES=200, no commits -> both conditions same cycle, done_cause=11.
REQ-043 RAT model x10->P7, x11->P9, PRF P7=0x0000_002A, P9=0xFFFF_FFFF -> a0_preg=7, a1_preg=9, a0_val=0x2A, a1_val=0xFFFF_FFFF; read sequence arch 10,11 then addr 7,9.
REQ-044 flush_i pulse 3 cycles, recover_i 2 cycles overlapping 1 -> flush_count=4.
REQ-045 rst_n asserted during PRF0 -> all outputs 0 immediately; after release, counting restarts from 0 in RUN.
